// File: rtl/shift_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module  : shift_ctrl_fsm
// Brief   : Run-time-length shift sequencer with WIDTH-bit shift register,
//           busy/done status, parallel load and one-deep request chaining.
// Revision: 1.0 - initial release
// ============================================================================
module shift_ctrl_fsm #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             din,
    output logic             Sh,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             ser_out
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             pend;
    logic [CNT_W-1:0] pend_len;

    logic len_nz;
    logic accept;
    logic last;
    logic live_req;
    logic chain;

    assign len_nz   = |len;
    assign accept   = (state == IDLE) && start && len_nz && !load;
    assign last     = (state == SHIFT) && (cnt == CNT_W'(1));
    assign live_req = mode && start && len_nz;
    assign chain    = pend || live_req;

    // Mealy shift enable: the accept cycle itself is the first shift cycle.
    assign Sh      = rst && ((state == SHIFT) || accept);
    assign busy    = (state == SHIFT);
    assign ser_out = dout[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            pend     <= 1'b0;
            pend_len <= '0;
            done     <= 1'b0;
            dout     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt <= len - 1'b1;
                        if (len == CNT_W'(1)) begin
                            done <= 1'b1;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (last) begin
                        done <= 1'b1;
                        // A queued request takes priority over a live one.
                        if (chain) begin
                            cnt  <= pend ? pend_len : len;
                            pend <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                        if (live_req && !pend) begin
                            pend     <= 1'b1;
                            pend_len <= len;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (Sh) begin
                dout <= {din, dout[WIDTH-1:1]};
            end else if (load && (state == IDLE)) begin
                dout <= load_data;
            end
        end
    end

endmodule
`default_nettype wire
